// File: rtl/mac_seq_pkg.sv
// Shared definitions for the dot-product sequencer.
// Contents:
//   state_e  - sequencer FSM states (IDLE, ACC, DONE)
//   OP_W     - operand width (4-bit unsigned multiplicand/multiplier)
//   ACC_W    - accumulator width (12-bit unsigned)
//   ACC_MAX  - accumulator ceiling, used as the saturation value
package mac_seq_pkg;

    localparam int OP_W  = 4;
    localparam int ACC_W = 12;

    localparam logic [ACC_W-1:0] ACC_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mac_dot_seq_mac_4bit.sv
// mac_4bit: combinational 4x4 multiply plus 12-bit accumulate.
// Ports:
//   a, b    in   OP_W   unsigned operands
//   c       in   ACC_W  addend (running accumulator, or 0 at vector start)
//   result  out  ACC_W  (a*b + c) modulo 2**ACC_W
//   cout    out  1      carry out of the 12-bit addition
module mac_4bit
    import mac_seq_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic [ACC_W-1:0] c,
    output logic [ACC_W-1:0] result,
    output logic             cout
);

    logic [2*OP_W-1:0] prod_s;
    logic [ACC_W:0]    sum_s;

    // Product is 8 bits wide; zero-extend it and add with one spare bit for the carry.
    always_comb begin
        prod_s = a * b;
        sum_s  = {{(ACC_W + 1 - 2 * OP_W){1'b0}}, prod_s} + {1'b0, c};
    end

    assign result = sum_s[ACC_W-1:0];
    assign cout   = sum_s[ACC_W];

endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences mac_4bit over a valid/ready stream of operand pairs
// and emits one 12-bit dot product per vector on a valid/ready result port.
// Build option: define SATURATE_EN to clamp the accumulator at 12'hFFF on the
// first carry-out of a vector; otherwise the sum wraps modulo 4096.
// Parameters:
//   MAX_LEN  maximum beats per vector; reaching it closes the vector (1..256)
//   CNT_W    width of the beat counter and res_len
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake (in_ready depends on state only)
//   in_a, in_b, in_last   operands and end-of-vector marker
//   res_valid/res_ready   result handshake
//   res_data, res_len     dot product and number of beats accumulated
//   res_ovf               a carry-out occurred somewhere in this vector
module mac_dot_seq
    import mac_seq_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_len,
    output logic             res_ovf
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_ACC  = 2'(ACC);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    // Counter is compared one bit wider so MAX_LEN == 2**CNT_W is reachable.
    localparam logic [CNT_W:0] MAX_LEN_C = (CNT_W + 1)'(MAX_LEN);

    logic [1:0]       state_r,  state_s;
    logic [ACC_W-1:0] acc_r,    acc_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic             ovf_r,    ovf_s;
    logic             in_ready_r;
    logic             res_valid_r;

    logic [ACC_W-1:0] mac_c_s;
    logic [ACC_W-1:0] mac_res_s;
    logic             mac_cout_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic             max_hit_s;
    logic             accept_s;

    mac_4bit u_mac (
        .a      (in_a),
        .b      (in_b),
        .c      (mac_c_s),
        .result (mac_res_s),
        .cout   (mac_cout_s)
    );

    // Next-state, accumulator, counter and overflow logic.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        ovf_s     = ovf_r;
        accept_s  = in_valid & in_ready_r;
        cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        max_hit_s = (cnt_inc_s == MAX_LEN_C);
        // The first beat of a vector starts from zero instead of the stale accumulator.
        if (state_r == ST_ACC) begin
            mac_c_s = acc_r;
        end else begin
            mac_c_s = {ACC_W{1'b0}};
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    acc_s = mac_res_s;
                    cnt_s = {{(CNT_W - 1){1'b0}}, 1'b1};
                    ovf_s = 1'b0;
                    if (in_last || (MAX_LEN == 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (accept_s) begin
                    cnt_s = cnt_inc_s[CNT_W-1:0];
                    ovf_s = ovf_r | mac_cout_s;
`ifdef SATURATE_EN
                    // Once a carry has been seen the result is pinned at the ceiling.
                    if (ovf_r || mac_cout_s) begin
                        acc_s = ACC_MAX;
                    end else begin
                        acc_s = mac_res_s;
                    end
`else
                    acc_s = mac_res_s;
`endif
                    if (in_last || max_hit_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_DONE: begin
                if (res_valid_r && res_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State registers; handshake flags are registered from the next state so
    // in_ready never sees a combinational path from res_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            ovf_r       <= ovf_s;
            in_ready_r  <= (state_s != ST_DONE);
            res_valid_r <= (state_s == ST_DONE);
        end
    end

    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = acc_r;
    assign res_len   = cnt_r;
    assign res_ovf   = ovf_r;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq. Two instances: one with MAX_LEN=32 for
// long vectors and randomized traffic, one with MAX_LEN=4 for forced vector end.
// Expected results come from an arithmetic reference model (exact integer sum).
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [3:0]  in_a = 4'd0, in_b = 4'd0;
    logic        in_last = 1'b0;
    logic        res_ready = 1'b1, res_ready4 = 1'b1;
    logic        in_ready, in_ready4;
    logic        res_valid, res_valid4;
    logic [11:0] res_data, res_data4;
    logic [7:0]  res_len, res_len4;
    logic        res_ovf, res_ovf4;

    int tests_run = 0;
    int errors = 0;

    typedef struct { int data; int len; int ovf; } res_t;
    res_t exp_q0[$];
    res_t exp_q1[$];
    int   cur_sum[2] = '{0, 0};
    int   cur_cnt[2] = '{0, 0};
    int   max_len[2] = '{32, 4};

    bit rr_random = 1'b0;
    bit rr_val = 1'b1;

    always #5 clk = ~clk;

    mac_dot_seq #(.MAX_LEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_len(res_len), .res_ovf(res_ovf)
    );

    mac_dot_seq #(.MAX_LEN(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .res_valid(res_valid4),
        .res_ready(res_ready4), .res_data(res_data4), .res_len(res_len4), .res_ovf(res_ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: exact unsigned sum, closed on last or on reaching MAX_LEN.
    task automatic model_beat(input int id, input logic [3:0] a, input logic [3:0] b, input logic l);
        res_t r;
        cur_sum[id] += int'(a) * int'(b);
        cur_cnt[id]++;
        if (l || cur_cnt[id] == max_len[id]) begin
            r.len = cur_cnt[id];
            r.ovf = (cur_sum[id] > 4095) ? 1 : 0;
`ifdef SATURATE_EN
            r.data = r.ovf ? 4095 : cur_sum[id];
`else
            r.data = cur_sum[id] % 4096;
`endif
            if (id == 0) exp_q0.push_back(r);
            else         exp_q1.push_back(r);
            cur_sum[id] = 0;
            cur_cnt[id] = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int id, input logic [3:0] a, input logic [3:0] b, input logic l);
        int t = 0;
        in_a = a; in_b = b; in_last = l;
        if (id == 0) in_valid = 1'b1; else in_valid4 = 1'b1;
        while ((((id == 0) ? in_ready : in_ready4) !== 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("in_ready_timeout", 32'd0, 32'd1);
        end else begin
            model_beat(id, a, b, l);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_valid4 = 1'b0;
    endtask

    // Idle cycles with garbage on the unaccepted operand lines.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_a = 4'($urandom); in_b = 4'($urandom); in_last = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("drain_timeout", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    // res_ready drivers update shortly after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            res_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_val;
        end
    end

    // Result monitor for the MAX_LEN=32 instance, with hold-stability checks.
    initial begin
        bit hold = 1'b0;
        logic [11:0] hd;
        logic [7:0] hl;
        logic ho;
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (res_valid) check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (hold) begin
                    check("hold_valid", 32'(res_valid), 32'd1);
                    check("hold_data", 32'(res_data), 32'(hd));
                    check("hold_len", 32'(res_len), 32'(hl));
                    check("hold_ovf", 32'(res_ovf), 32'(ho));
                end
                if (res_valid && res_ready) begin
                    if (exp_q0.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q0.pop_front();
                        check("res_data", 32'(res_data), 32'(e.data));
                        check("res_len", 32'(res_len), 32'(e.len));
                        check("res_ovf", 32'(res_ovf), 32'(e.ovf));
                    end
                end
                hold = res_valid && !res_ready;
                hd = res_data; hl = res_len; ho = res_ovf;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Result monitor for the MAX_LEN=4 instance.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid4 && res_ready4) begin
                if (exp_q1.size() == 0) begin
                    check("unexpected_result4", 32'd1, 32'd0);
                end else begin
                    e = exp_q1.pop_front();
                    check("res_data4", 32'(res_data4), 32'(e.data));
                    check("res_len4", 32'(res_len4), 32'(e.len));
                    check("res_ovf4", 32'(res_ovf4), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_len", 32'(res_len), 32'd0);
        check("rst_res_ovf", 32'(res_ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector: 3*5 + 2*7 = 29, result one cycle after the last beat.
        send(0, 4'd3, 4'd5, 1'b0);
        check("basic_no_early_valid", 32'(res_valid), 32'd0);
        send(0, 4'd2, 4'd7, 1'b1);
        check("basic_latency", 32'(res_valid), 32'd1);
        check("basic_data_const", 32'(res_data), 32'd29);
        wait_drain();

        // Single beat.
        send(0, 4'd15, 4'd15, 1'b1);
        check("single_valid", 32'(res_valid), 32'd1);
        check("single_in_ready", 32'(in_ready), 32'd0);
        wait_drain();

        // Overflow: 19 beats of 15*15 (exact 4275).
        for (int i = 1; i <= 19; i++) send(0, 4'd15, 4'd15, (i == 19));
`ifdef SATURATE_EN
        check("ovf_data_const", 32'(res_data), 32'd4095);
`else
        check("ovf_data_const", 32'(res_data), 32'd179);
`endif
        wait_drain();

        // Backpressure: result held for 5 cycles with res_ready low.
        rr_val = 1'b0;
        @(negedge clk);
        send(0, 4'd9, 4'd4, 1'b0);
        send(0, 4'd1, 4'd3, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_data", 32'(res_data), 32'd39);
            check("bp_len", 32'(res_len), 32'd2);
            @(negedge clk);
        end
        rr_val = 1'b1;
        wait_drain();
        send(0, 4'd1, 4'd1, 1'b1);
        wait_drain();

        // Forced end at MAX_LEN=4, then the next vector picks up at beat 5.
        for (int i = 1; i <= 6; i++) begin
            send(1, 4'd1, 4'd2, 1'b0);
            if (i == 4) check("forced_end_valid", 32'(res_valid4), 32'd1);
        end
        send(1, 4'd1, 4'd2, 1'b1);
        wait_drain();

        // Reset mid-vector discards the partial vector.
        send(0, 4'd7, 4'd7, 1'b0);
        send(0, 4'd6, 4'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        check("midrst_res_data", 32'(res_data), 32'd0);
        check("midrst_res_len", 32'(res_len), 32'd0);
        check("midrst_res_ovf", 32'(res_ovf), 32'd0);
        cur_sum[0] = 0;
        cur_cnt[0] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send(0, 4'd2, 4'd3, 1'b1);
        wait_drain();

        // Randomized traffic with gaps, forced ends and random backpressure.
        rr_random = 1'b1;
        for (int v = 0; v < 40; v++) begin
            int len = $urandom_range(1, 40);
            for (int k = 1; k <= len; k++) begin
                idle($urandom_range(0, 2));
                send(0, 4'($urandom), 4'($urandom), (k == len));
            end
        end
        wait_drain();
        rr_random = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

endmodule
